// File: rtl/msi_pkg.sv
// MSI message generator shared types, constants and vector-allocation helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package msi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } msi_state_t;

  localparam int MSI_MAX_VEC = 32;

  // log2 of the allocated vector count: mme saturates at 5 (6/7 read as 5)
  // and never exceeds what the function actually requested.
  function automatic int alloc_log2(input logic [2:0] mme, input int num_vec);
    int nlog;
    int m;
    nlog = $clog2(num_vec);
    m    = (mme > 3'd5) ? 5 : int'(mme);
    return (m < nlog) ? m : nlog;
  endfunction

  // Sources beyond the allocated range fold onto the last allocated vector.
  function automatic int eff_vec(input int v, input logic [2:0] mme, input int num_vec);
    int alloc;
    alloc = 1 << alloc_log2(mme, num_vec);
    return (v < alloc) ? v : alloc - 1;
  endfunction

endpackage

// File: rtl/msi_priority_encoder.sv
// Lowest-index select over a request vector.
// Latency: purely combinational.
// Backpressure: none; any/idx follow req directly.
module msi_priority_encoder #(
  parameter int NUM_VEC = 32,
  parameter int IDX_W   = 5
) (
  input  logic [NUM_VEC-1:0] req,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the last hit (the lowest index) wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/msi_message_generator.sv
// Collects interrupt pulses into pending bits and emits one MSI memory write per message.
// Latency: int_req at cycle N -> pending at N+1 -> req_valid at N+2; at most one message per 2 cycles.
// Backpressure: request held stable in SEND until req_ready; new pulses keep accumulating as pending bits.
module msi_message_generator
  import msi_pkg::*;
#(
  parameter int NUM_VEC = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msi_enable,
  input  logic [2:0]         mme,
  input  logic [31:0]        msg_addr,
  input  logic [15:0]        msg_data,
  input  logic [NUM_VEC-1:0] mask_bits,
  input  logic [NUM_VEC-1:0] int_req,
  output logic [NUM_VEC-1:0] pending_bits,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [31:0]        req_addr,
  output logic [31:0]        req_data,
  output logic               msg_sent
);

  localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  msi_state_t         state_q;
  msi_state_t         state_d;
  logic [NUM_VEC-1:0] pending_q;
  logic [NUM_VEC-1:0] pending_d;
  logic [NUM_VEC-1:0] set_vec;
  logic [NUM_VEC-1:0] clr_vec;
  logic [NUM_VEC-1:0] eligible;
  logic               sel_any;
  logic [IDX_W-1:0]   sel_idx;
  logic               load;
  logic [31:0]        req_addr_q;
  logic [31:0]        req_data_q;
  logic [15:0]        low_mask;
  logic [15:0]        merged_data;
  int                 k_log;

  // Address bits [1:0] are forced to zero on the request.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, msg_addr[1:0]};

  assign eligible = pending_q & ~mask_bits;

  msi_priority_encoder #(
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req (eligible),
    .any (sel_any),
    .idx (sel_idx)
  );

  // Map each source pulse onto its effective (possibly aliased) vector.
  always_comb begin
    set_vec = '0;
    for (int t = 0; t < NUM_VEC; t++) begin
      for (int v = 0; v < NUM_VEC; v++) begin
        if (int_req[v] && (eff_vec(v, mme, NUM_VEC) == t)) begin
          set_vec[t] = 1'b1;
        end
      end
    end
  end

  // Next state: pick a message in IDLE, wait out the handshake in SEND.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (msi_enable && sel_any) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (req_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear the selected bit on load; a same-cycle pulse re-sets it (set wins).
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (load && (sel_idx == IDX_W'(i))) begin
        clr_vec[i] = 1'b1;
      end
    end
    pending_d = msi_enable ? ((pending_q & ~clr_vec) | set_vec) : '0;
  end

  // Merge the vector number into the low log2(ALLOC) bits of Message Data.
  always_comb begin
    k_log       = alloc_log2(mme, NUM_VEC);
    low_mask    = 16'((1 << k_log) - 1);
    merged_data = (msg_data & ~low_mask) | (16'(sel_idx) & low_mask);
  end

  // State, pending bits and the request payload captured on IDLE->SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load) begin
        req_addr_q <= {msg_addr[31:2], 2'b00};
        req_data_q <= {16'h0000, merged_data};
      end
    end
  end

  assign pending_bits = pending_q;
  assign req_valid    = (state_q == SEND);
  assign req_addr     = req_addr_q;
  assign req_data     = req_data_q;
  assign msg_sent     = req_valid & req_ready;

endmodule

// File: tb/tb_msi_message_generator.sv
// Self-checking bench for msi_message_generator: table of single-message vectors plus
// hand-written sequences for masking, backpressure, disable, collision and reset in SEND.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_msi_message_generator;

  localparam int NV = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          msi_enable;
  logic [2:0]    mme;
  logic [31:0]   msg_addr;
  logic [15:0]   msg_data;
  logic [NV-1:0] mask_bits;
  logic [NV-1:0] int_req;
  logic [NV-1:0] pending_bits;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic          msg_sent;

  int errors = 0;
  int checks = 0;

  msi_message_generator #(.NUM_VEC(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .msi_enable   (msi_enable),
    .mme          (mme),
    .msg_addr     (msg_addr),
    .msg_data     (msg_data),
    .mask_bits    (mask_bits),
    .int_req      (int_req),
    .pending_bits (pending_bits),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .msg_sent     (msg_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mme;
    logic [31:0] addr;
    logic [15:0] data;
    int          vec;
    int          ev;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bit_ev;

    // mme, addr, data, source, effective vector, expected addr, expected data
    tbl[0] = '{3'd5, 32'hFEE0_1003, 16'h4020,  3,  3, 32'hFEE0_1000, 32'h0000_4023};
    tbl[1] = '{3'd2, 32'h1234_5677, 16'hABCD,  9,  3, 32'h1234_5674, 32'h0000_ABCF};
    tbl[2] = '{3'd0, 32'h0000_0002, 16'h5A5F, 17,  0, 32'h0000_0000, 32'h0000_5A5F};
    tbl[3] = '{3'd7, 32'hFEE0_0004, 16'h1234, 31, 31, 32'hFEE0_0004, 32'h0000_123F};
    tbl[4] = '{3'd3, 32'h8000_0001, 16'h00FF,  5,  5, 32'h8000_0000, 32'h0000_00FD};
    tbl[5] = '{3'd1, 32'hDEAD_BEEF, 16'h8001,  0,  0, 32'hDEAD_BEEC, 32'h0000_8000};
    tbl[6] = '{3'd6, 32'hFEE0_0FF0, 16'hC3C0, 20, 20, 32'hFEE0_0FF0, 32'h0000_C3D4};

    rst        = 1'b1;
    msi_enable = 1'b1;
    mme        = 3'd5;
    msg_addr   = 32'hFEE0_1003;
    msg_data   = 16'h4020;
    mask_bits  = '0;
    int_req    = '0;
    req_ready  = 1'b1;

    nxt(); nxt();
    chk("rst_valid",   {31'd0, req_valid}, 32'd0);
    chk("rst_pending", pending_bits,       32'd0);
    chk("rst_addr",    req_addr,           32'd0);
    chk("rst_data",    req_data,           32'd0);
    chk("rst_sent",    {31'd0, msg_sent},  32'd0);
    rst = 1'b0;
    nxt();

    // Single messages with req_ready tied high.
    for (int i = 0; i < 7; i++) begin
      mme      = tbl[i].mme;
      msg_addr = tbl[i].addr;
      msg_data = tbl[i].data;
      int_req  = '0;
      int_req[tbl[i].vec] = 1'b1;
      bit_ev   = 32'd1 << tbl[i].ev;
      nxt();
      int_req = '0;
      chk("tbl_pend_set", pending_bits,       bit_ev);
      chk("tbl_valid_n1", {31'd0, req_valid}, 32'd0);
      nxt();
      chk("tbl_valid",    {31'd0, req_valid}, 32'd1);
      chk("tbl_addr",     req_addr,           tbl[i].exp_addr);
      chk("tbl_data",     req_data,           tbl[i].exp_data);
      chk("tbl_pend_clr", pending_bits,       32'd0);
      chk("tbl_sent",     {31'd0, msg_sent},  32'd1);
      nxt();
      chk("tbl_valid_drop", {31'd0, req_valid}, 32'd0);
      chk("tbl_sent_drop",  {31'd0, msg_sent},  32'd0);
    end

    // Masking: vector 5 held pending while masked, sent once unmasked.
    mme       = 3'd5;
    msg_addr  = 32'hFEE0_1003;
    msg_data  = 16'h4020;
    mask_bits = 32'h0000_0020;
    int_req   = 32'h0000_0020;
    nxt();
    int_req = '0;
    for (int i = 0; i < 20; i++) begin
      chk("mask_no_valid", {31'd0, req_valid}, 32'd0);
      nxt();
    end
    chk("mask_pending", pending_bits, 32'h0000_0020);
    mask_bits = '0;
    nxt();
    chk("unmask_valid",   {31'd0, req_valid}, 32'd1);
    chk("unmask_data",    req_data,           32'h0000_4025);
    chk("unmask_pending", pending_bits,       32'd0);
    nxt();
    chk("unmask_drop", {31'd0, req_valid}, 32'd0);

    // Arbitration and backpressure: vectors 2 and 7 together, ready low.
    req_ready = 1'b0;
    int_req   = 32'h0000_0084;
    nxt();
    int_req = '0;
    chk("arb_pending", pending_bits, 32'h0000_0084);
    nxt();
    chk("arb_valid",   {31'd0, req_valid}, 32'd1);
    chk("arb_data2",   req_data,           32'h0000_4022);
    chk("arb_pend7",   pending_bits,       32'h0000_0080);
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("bp_valid_hold", {31'd0, req_valid}, 32'd1);
      chk("bp_data_hold",  req_data,           32'h0000_4022);
      chk("bp_addr_hold",  req_addr,           32'hFEE0_1000);
      chk("bp_no_sent",    {31'd0, msg_sent},  32'd0);
    end
    req_ready = 1'b1;
    #1;
    chk("bp_sent", {31'd0, msg_sent}, 32'd1);
    nxt();
    chk("bp_idle_gap", {31'd0, req_valid}, 32'd0);
    chk("bp_pend7",    pending_bits,       32'h0000_0080);
    nxt();
    chk("arb_valid7", {31'd0, req_valid}, 32'd1);
    chk("arb_data7",  req_data,           32'h0000_4027);
    chk("arb_pend0",  pending_bits,       32'd0);
    nxt();
    chk("arb_drop", {31'd0, req_valid}, 32'd0);

    // Disable clears pending bits and ignores pulses.
    mask_bits = 32'h0000_0002;
    int_req   = 32'h0000_0002;
    nxt();
    int_req = '0;
    chk("dis_pend_set", pending_bits, 32'h0000_0002);
    nxt();
    chk("dis_no_valid0", {31'd0, req_valid}, 32'd0);
    msi_enable = 1'b0;
    nxt();
    chk("dis_pend_clr",  pending_bits,       32'd0);
    chk("dis_no_valid1", {31'd0, req_valid}, 32'd0);
    int_req = 32'h0000_0010;
    nxt();
    int_req = '0;
    chk("dis_ignore", pending_bits, 32'd0);
    nxt();
    chk("dis_no_valid2", {31'd0, req_valid}, 32'd0);
    msi_enable = 1'b1;
    mask_bits  = '0;
    nxt();
    chk("reen_pending", pending_bits, 32'd0);
    nxt();
    chk("reen_no_valid", {31'd0, req_valid}, 32'd0);

    // Collision: pulse on vector 4 in the cycle it is selected.
    int_req = 32'h0000_0010;
    nxt();
    chk("col_pend", pending_bits, 32'h0000_0010);
    nxt();
    int_req = '0;
    chk("col_valid1", {31'd0, req_valid}, 32'd1);
    chk("col_data1",  req_data,           32'h0000_4024);
    chk("col_repend", pending_bits,       32'h0000_0010);
    nxt();
    chk("col_gap", {31'd0, req_valid}, 32'd0);
    nxt();
    chk("col_valid2", {31'd0, req_valid}, 32'd1);
    chk("col_data2",  req_data,           32'h0000_4024);
    chk("col_pend0",  pending_bits,       32'd0);
    nxt();
    chk("col_drop", {31'd0, req_valid}, 32'd0);

    // Reset while a request is waiting in SEND drops it.
    req_ready = 1'b0;
    int_req   = 32'h0000_0040;
    nxt();
    int_req = '0;
    nxt();
    chk("rs_valid", {31'd0, req_valid}, 32'd1);
    rst = 1'b1;
    nxt();
    chk("rs_drop",    {31'd0, req_valid}, 32'd0);
    chk("rs_addr",    req_addr,           32'd0);
    chk("rs_data",    req_data,           32'd0);
    chk("rs_pending", pending_bits,       32'd0);
    rst       = 1'b0;
    req_ready = 1'b1;
    nxt();
    chk("rs_idle", {31'd0, req_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msi_message_generator.md
# msi_message_generator

Generates MSI memory-write requests for a PCIe function. Collects per-vector interrupt pulses into pending bits, applies per-vector masking, arbitrates the pending vectors and emits one request per message. Each request carries the programmed Message Address and the Message Data with the vector number merged into its low bits. The block sits directly downstream of the MSI capability registers (Message Address, Message Data, Mask, Control) and upstream of the TLP transmit path.

## Interface
- NUM_VEC, default 32, number of interrupt sources/vectors requested; power of two, 1..32
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- msi_enable  input  1  MSI Enable from Message Control
- mme  input  3  Multiple Message Enable from Message Control; encoded 2^mme vectors
- msg_addr  input  32  Message Address register value; bits [1:0] ignored
- msg_data  input  16  Message Data register value
- mask_bits  input  NUM_VEC  per-vector Mask Bits register
- int_req  input  NUM_VEC  one-cycle interrupt pulses, one bit per source
- pending_bits  output  NUM_VEC  Pending Bits register value (read-only to software)
- req_valid  output  1  memory-write request valid
- req_ready  input  1  transmit path accepts request
- req_addr  output  32  write address, {msg_addr[31:2], 2'b00}
- req_data  output  32  write payload dword
- msg_sent  output  1  one-cycle pulse when a request is accepted

## Operation
- Allocated vector count `ALLOC = 2^min(mme, log2(NUM_VEC))`. mme values 6 and 7 are treated as 5.
- Effective vector for source v: `ev = min(v, ALLOC-1)`. Sources at or above ALLOC alias onto the last allocated vector.
- Pending set: when msi_enable=1 and int_req[v]=1, pending[ev] <= 1. Multiple sources may set bits in the same cycle.
- Pending clear: when msi_enable=0, all pending bits <= 0 on every cycle. A request already in SEND is unaffected.
- States:
  - IDLE: if msi_enable=1 and any (pending & ~mask_bits) is set:
    - select the lowest-index such vector s;
    - clear pending[s], capture s, drive req_valid=1;
    - go to SEND.
  - SEND: hold req_valid, req_addr and req_data stable until req_ready=1.
    - On the req_valid & req_ready cycle, pulse msg_sent and go to IDLE.
    - Masking, disable or register changes in SEND do not abort or alter the request.
- Simultaneous set and clear of the same bit: set wins. int_req for vector s in the cycle s is selected leaves pending[s]=1.
- Masked pending bits stay pending. They are sent in lowest-index order once unmasked.
- req_addr = {msg_addr[31:2], 2'b00}, captured on IDLE->SEND.
- Data merge, with `k = log2(ALLOC)`: req_data = {16'h0, msg_data[15:k], s[k-1:0]}. When k=0, req_data = {16'h0, msg_data}. Captured on IDLE->SEND.

## Timing
- Reset values: state=IDLE, pending_bits=0, req_valid=0, req_addr=0, req_data=0, msg_sent=0.
- Latency: int_req at cycle N sets pending at N+1, and req_valid is high at N+2 with pending[s] already cleared.
- With req_ready tied high, req_valid lasts one cycle and msg_sent is high in that same cycle.
- At least one IDLE cycle follows each accept. Peak rate is one message per 2 cycles.
- rst during SEND drops req_valid the next cycle; the message is lost.
- No combinational path from req_ready to req_valid.

## Structure
- Package msi_pkg holds:
  - typedef enum for states {IDLE, SEND};
  - constant MSI_MAX_VEC=32;
  - function eff_vec(v, mme, NUM_VEC);
  - function alloc_log2(mme, NUM_VEC).
- One sub-module, msi_priority_encoder: combinational lowest-index select over NUM_VEC bits, with outputs any and idx.

## Test plan
- Reset/basic: NUM_VEC=32, mme=5, msg_addr=32'hFEE0_1003, msg_data=16'h4020, int_req[3] pulse -> req_valid at +2 cycles, req_addr=32'hFEE0_1000, req_data=32'h0000_4023, pending_bits back to 0.
- Aliasing: mme=2 (4 vectors), int_req[9] pulse -> pending_bits[3]=1; request req_data={16'h0, msg_data[15:2], 2'b11}.
- Masking: mask_bits[5]=1, pulse int_req[5] -> no req_valid for 20 cycles, pending_bits[5]=1; clear mask -> request for vector 5 within 2 cycles.
- Arbitration/backpressure: pulse int_req[7] and int_req[2] together, req_ready=0 for 5 cycles -> vector 2 held stable, then vector 7 sent after accept plus one IDLE cycle.
- Disable: pending bits set with mask_bits[1]=1 -> msi_enable=0 -> pending_bits=0 next cycle, no req_valid. Int_req while disabled is ignored.
- Collision: int_req[4] asserted in the cycle vector 4 is selected -> second message for vector 4 follows the first.
